// File: rtl/tpx3_readout_pkg.sv
// Shared types and sizing helpers for the Timepix3 readout merger.
package tpx3_readout_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Sized for the largest supported burst so one counter width fits every build.
    localparam int MAX_BURST_LIMIT = 256;
    localparam int BURST_CNT_W     = clog2(MAX_BURST_LIMIT + 1);

endpackage

// File: rtl/tpx3_readout_merger_rr_next_sel.sv
// Rotating priority encoder: first set request at or after start_i, wrapping modulo N.
module rr_next_sel #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        // Walk from the far end so the candidate nearest start_i overwrites last.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(start_i) + k) % N]) begin
                idx_o   = IDX_W'((int'(start_i) + k) % N);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tpx3_readout_merger.sv
// Merges N FWFT channel FIFOs into one FWFT stream with bounded-burst round-robin,
// enable mask, optional channel-ID tagging and saturating per-channel word counters.
module tpx3_readout_merger
    import tpx3_readout_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter bit ID_EN      = 1'b1,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         BUS_CLK,
    input  logic                         BUS_RST_N,
    input  logic [N_CH-1:0]              EN_MASK,
    input  logic                         CNT_CLR,
    input  logic [N_CH-1:0]              IN_EMPTY,
    output logic [N_CH-1:0]              IN_READ,
    input  logic [N_CH*DATA_WIDTH-1:0]   IN_DATA,
    input  logic                         OUT_READ,
    output logic                         OUT_EMPTY,
    output logic [DATA_WIDTH-1:0]        OUT_DATA,
    output logic [ID_WIDTH-1:0]          OUT_CH,
    output logic [N_CH*CNT_WIDTH-1:0]    WORD_CNT,
    output logic                         BUSY,
    output logic                         DBG_STATE
);

    localparam int CH_W = clog2(N_CH);
    localparam logic [BURST_CNT_W-1:0] MAX_B = BURST_CNT_W'(MAX_BURST);

    // Handshake: IN_READ[i] high means channel i's head word is consumed at this
    // edge; OUT_READ consumes OUT_DATA at this edge only while OUT_EMPTY is low.

    state_e                          state_q, state_d;
    logic [CH_W-1:0]                 ptr_q, ptr_d;
    logic [BURST_CNT_W-1:0]          bcnt_q, bcnt_d;
    logic                            out_empty_q;
    logic [DATA_WIDTH-1:0]           out_data_q;
    logic [ID_WIDTH-1:0]             out_ch_q;
    logic [N_CH-1:0][CNT_WIDTH-1:0]  cnt_q;

    logic [N_CH-1:0][DATA_WIDTH-1:0] in_word;
    logic [N_CH-1:0]                 eligible;
    logic                            load_ok;
    logic [CH_W-1:0]                 start;
    logic [CH_W-1:0]                 sel_idx;
    logic                            sel_valid;
    logic                            burst_cont;
    logic                            rd_en;
    logic [CH_W-1:0]                 rd_ch;
    logic [N_CH-1:0]                 rd_vec;
    logic [DATA_WIDTH-1:0]           head_word;
    logic [DATA_WIDTH-1:0]           load_word;

    assign in_word  = IN_DATA;
    assign eligible = EN_MASK & ~IN_EMPTY;
    assign load_ok  = out_empty_q | OUT_READ;
    assign start    = (ptr_q == CH_W'(N_CH - 1)) ? '0 : ptr_q + 1'b1;

    rr_next_sel #(
        .N     (N_CH),
        .IDX_W (CH_W)
    ) u_sel (
        .req_i   (eligible),
        .start_i (start),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // A burst that cannot continue falls straight into reselection, so there is no bubble.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        bcnt_d     = bcnt_q;
        rd_en      = 1'b0;
        rd_ch      = ptr_q;
        burst_cont = (state_q == BURST) && eligible[ptr_q] && (bcnt_q < MAX_B);
        if (BUS_RST_N && load_ok) begin
            if (burst_cont) begin
                rd_en  = 1'b1;
                bcnt_d = bcnt_q + 1'b1;
            end else if (sel_valid) begin
                rd_en   = 1'b1;
                rd_ch   = sel_idx;
                ptr_d   = sel_idx;
                bcnt_d  = BURST_CNT_W'(1);
                state_d = (MAX_BURST > 1) ? BURST : IDLE;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        rd_vec = '0;
        if (rd_en) begin
            rd_vec[rd_ch] = 1'b1;
        end
        head_word = in_word[rd_ch];
        if (ID_EN) begin
            load_word = {ID_WIDTH'(rd_ch), head_word[DATA_WIDTH-ID_WIDTH-1:0]};
        end else begin
            load_word = head_word;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            state_q     <= IDLE;
            ptr_q       <= CH_W'(N_CH - 1);
            bcnt_q      <= '0;
            out_empty_q <= 1'b1;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            if (rd_en) begin
                out_empty_q <= 1'b0;
                out_data_q  <= load_word;
                out_ch_q    <= ID_WIDTH'(rd_ch);
            end else if (OUT_READ) begin
                out_empty_q <= 1'b1;
            end
        end
    end

    // A clear coinciding with a read leaves that channel at 1, not 0.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (CNT_CLR) begin
                    cnt_q[i] <= {{(CNT_WIDTH-1){1'b0}}, rd_vec[i]};
                end else if (rd_vec[i] && !(&cnt_q[i])) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign IN_READ   = rd_vec;
    assign OUT_EMPTY = out_empty_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_CH    = out_ch_q;
    assign WORD_CNT  = cnt_q;
    assign BUSY      = (state_q == BURST) | ~out_empty_q;
    assign DBG_STATE = state_q;

endmodule

// File: doc/tpx3_readout_merger.md
Name: tpx3_readout_merger

Overview:
- Parametrised N-channel successor to the fixed two-input readout arbitration in the Timepix3 core.
- Merges N first-word-fall-through (FWFT) 32-bit channel FIFOs (one per tpx3_rx lane, plus test sources) into one FWFT stream that feeds the BRAM output FIFO.
- Adds bounded-burst round-robin arbitration, a per-channel enable mask, optional channel-ID tagging in the upper data bits, and saturating per-channel word counters.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_WIDTH, 32, word width.
- ID_WIDTH, 4, tag width; must be >= clog2(N_CH) and < DATA_WIDTH.
- ID_EN, 1, 1 = overwrite OUT_DATA[DATA_WIDTH-1 -: ID_WIDTH] with the channel index.
- MAX_BURST, 16, maximum consecutive words per grant (1..256).
- CNT_WIDTH, 32, width of each word counter.

Ports:
- BUS_CLK  in  1  single clock.
- BUS_RST_N  in  1  reset, synchronous, active-low.
- EN_MASK  in  N_CH  per-channel enable; a disabled channel is never read.
- CNT_CLR  in  1  one-cycle pulse; clears all word counters.
- IN_EMPTY  in  N_CH  channel FIFO empty flags.
- IN_READ  out  N_CH  one-hot read strobe; the word is taken in the same cycle.
- IN_DATA  in  N_CH*DATA_WIDTH  channel FIFO head words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- OUT_READ  in  1  downstream consume strobe.
- OUT_EMPTY  out  1  output register holds no word.
- OUT_DATA  out  DATA_WIDTH  output word (tagged if ID_EN).
- OUT_CH  out  ID_WIDTH  source channel of OUT_DATA.
- WORD_CNT  out  N_CH*CNT_WIDTH  per-channel transferred-word counts.
- BUSY  out  1  state is BURST or the output register is valid.

Behaviour:
- Reset (BUS_RST_N=0 at a BUS_CLK edge):
  - OUT_EMPTY=1, OUT_DATA=0, OUT_CH=0, IN_READ=0, WORD_CNT=0, BUSY=0.
  - Grant pointer = N_CH-1, so channel 0 is considered first.
  - State=IDLE, burst count=0.
  - Reset mid-burst discards the output-register word. Words already read from the channel FIFOs are lost; this is accepted.
- Output register:
  - A one-entry FWFT stage.
  - load_ok = OUT_EMPTY | OUT_READ.
  - OUT_READ while OUT_EMPTY=1 is ignored.
- Candidate: channel i is eligible when EN_MASK[i] & ~IN_EMPTY[i].
- IDLE:
  - When load_ok and some channel is eligible, select g = first eligible channel after the grant pointer, wrapping modulo N_CH. This is done by rr_next_sel.
  - Same cycle: IN_READ[g]=1. Next edge: capture IN_DATA[g] and g, set OUT_EMPTY=0, burst count=1, pointer=g.
  - Go to BURST if MAX_BURST>1, else stay in IDLE.
- BURST (stays on channel pointer):
  - When load_ok, channel pointer eligible, and burst count<MAX_BURST: read again and increment burst count.
  - If channel pointer is not eligible (empty or disabled) or burst count==MAX_BURST: return to IDLE. In the same cycle, perform the IDLE selection from pointer+1, so there is no bubble when another channel is eligible.
  - If the burst ends and no other channel is eligible, the same channel may win again in that selection.
  - If load_ok=0, hold state; IN_READ=0.
- Throughput: 1 word/cycle while OUT_READ is held high and data is available. Latency from IN_READ to OUT_EMPTY=0 is 1 cycle.
- IN_READ:
  - At most one bit high per cycle.
  - Never asserted for an empty or disabled channel.
  - Never asserted when load_ok=0.
- Tagging: if ID_EN, OUT_DATA = {g[ID_WIDTH-1:0], IN_DATA[g][DATA_WIDTH-ID_WIDTH-1:0]}; otherwise data passes unmodified.
- Counters:
  - WORD_CNT[i] increments on each IN_READ[i] and saturates at all-ones.
  - If CNT_CLR and IN_READ[i] occur in the same cycle, WORD_CNT[i] becomes 1; all other counters become 0.
- EN_MASK changes apply in the same cycle. Deasserting the granted channel's enable ends its burst before the next read.

Decomposition:
- Package tpx3_readout_pkg:
  - state enum {IDLE, BURST};
  - clog2 function;
  - localparam for the burst counter width, clog2(MAX_BURST+1).
- Sub-module rr_next_sel:
  - combinational rotating priority encoder over N_CH;
  - inputs: request vector, start index;
  - outputs: index, valid.

Test Plan:
- N_CH=4, only ch2 enabled and holding 5 words, OUT_READ=1 continuous -> 5 consecutive words with OUT_DATA[31:28]=2 and OUT_CH=2; WORD_CNT[2]=5, others 0.
- All 4 channels full (40 words each), MAX_BURST=16, OUT_READ=1 -> grants in order ch0×16, ch1×16, ch2×16, ch3×16, ch0×16…; no idle cycle between bursts; every IN_READ is one-hot.
- ch0 and ch1 each hold 3 words, OUT_READ=0 -> exactly 1 IN_READ, then stall with OUT_EMPTY=0. Release OUT_READ -> remaining 5 words follow, no loss or duplication.
- Burst on ch1, deassert EN_MASK[1] after the 2nd word while ch3 is eligible -> no further IN_READ[1]; next read is ch3 in the same cycle the burst ends.
- CNT_CLR in the same cycle as IN_READ[0] with WORD_CNT[0]=7 -> WORD_CNT[0]=1 on the next cycle; with CNT_WIDTH=4 and 20 words, WORD_CNT saturates at 15.
- BUS_RST_N=0 for one cycle mid-burst with OUT_EMPTY=0 -> next cycle OUT_EMPTY=1, WORD_CNT=0, first grant after release goes to the lowest eligible channel.
